// File: rtl/serial_comparator_ctrl.sv
// -----------------------------------------------------------------------------
// serial_comparator_ctrl
// Compares two unsigned WIDTH-bit operands by walking them two bits at a time,
// MSB slice first, through an external combinational 2-bit comparator.
// The walk stops as soon as a slice differs, so an early difference finishes
// in fewer cycles than an equal pair of operands.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              compare request, only looked at while idle
//   op_a, op_b         operands, captured when start is accepted
//   cmp_a1/a2, b1/b2   current slice driven to the comparator (x1 = MSB)
//   cmp_f1/f2/f3       comparator response: A>B, A==B, A<B
//   busy               high while a comparison is in flight (CMP or DONE)
//   done               one-cycle pulse when gt/eq/lt/err are valid
//   gt, eq, lt         final result, held until the next accepted start
//   err                comparator gave a non-one-hot response
// -----------------------------------------------------------------------------
module serial_comparator_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             cmp_a1,
   output logic             cmp_a2,
   output logic             cmp_b1,
   output logic             cmp_b2,
   input  logic             cmp_f1,
   input  logic             cmp_f2,
   input  logic             cmp_f3,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic             err
);

   localparam int SLICES = WIDTH / 2;
   localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMP  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // True when exactly one of the three response bits is set.
   function automatic logic is_onehot3(input logic [2:0] v);
      return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
   endfunction

   logic [1:0]       state_r,  state_s;
   logic [IW-1:0]    idx_r,    idx_s;
   logic [WIDTH-1:0] opa_r,    opa_s;
   logic [WIDTH-1:0] opb_r,    opb_s;
   logic [1:0]       cmpa_r,   cmpa_s;
   logic [1:0]       cmpb_r,   cmpb_s;
   logic             busy_r,   busy_s;
   logic             done_r,   done_s;
   logic             gt_r,     gt_s;
   logic             eq_r,     eq_s;
   logic             lt_r,     lt_s;
   logic             err_r,    err_s;
   logic [2:0]       f_s;
   logic [IW-1:0]    idx_dec_s;

   assign f_s       = {cmp_f1, cmp_f2, cmp_f3};
   assign idx_dec_s = idx_r - {{(IW-1){1'b0}}, 1'b1};

   // Next-state and next-output logic. The comparator slice is registered one
   // cycle ahead so it is already stable during the CMP cycle that samples f.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      opa_s   = opa_r;
      opb_s   = opb_r;
      cmpa_s  = 2'b00;
      cmpb_s  = 2'b00;
      gt_s    = gt_r;
      eq_s    = eq_r;
      lt_s    = lt_r;
      err_s   = err_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_CMP;
               opa_s   = op_a;
               opb_s   = op_b;
               idx_s   = IW'(SLICES - 1);
               cmpa_s  = op_a[WIDTH-1 -: 2];
               cmpb_s  = op_b[WIDTH-1 -: 2];
               gt_s    = 1'b0;
               eq_s    = 1'b0;
               lt_s    = 1'b0;
               err_s   = 1'b0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CMP: begin
            if (!is_onehot3(f_s)) begin
               err_s   = 1'b1;
               state_s = ST_DONE;
            end else if (f_s[2]) begin
               gt_s    = 1'b1;
               state_s = ST_DONE;
            end else if (f_s[0]) begin
               lt_s    = 1'b1;
               state_s = ST_DONE;
            end else if (idx_r == {IW{1'b0}}) begin
               eq_s    = 1'b1;
               state_s = ST_DONE;
            end else begin
               // Slices equal so far: move on to the next lower slice.
               idx_s   = idx_dec_s;
               cmpa_s  = opa_r[{idx_dec_s, 1'b0} +: 2];
               cmpb_s  = opb_r[{idx_dec_s, 1'b0} +: 2];
               state_s = ST_CMP;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            // Unused encoding: return to IDLE with a clean result.
            state_s = ST_IDLE;
            idx_s   = {IW{1'b0}};
            gt_s    = 1'b0;
            eq_s    = 1'b0;
            lt_s    = 1'b0;
            err_s   = 1'b0;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
      done_s = (state_s == ST_DONE);
   end

   // State, operand and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         idx_r   <= {IW{1'b0}};
         opa_r   <= {WIDTH{1'b0}};
         opb_r   <= {WIDTH{1'b0}};
         cmpa_r  <= 2'b00;
         cmpb_r  <= 2'b00;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         gt_r    <= 1'b0;
         eq_r    <= 1'b0;
         lt_r    <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         opa_r   <= opa_s;
         opb_r   <= opb_s;
         cmpa_r  <= cmpa_s;
         cmpb_r  <= cmpb_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         gt_r    <= gt_s;
         eq_r    <= eq_s;
         lt_r    <= lt_s;
         err_r   <= err_s;
      end
   end

   assign cmp_a1 = cmpa_r[1];
   assign cmp_a2 = cmpa_r[0];
   assign cmp_b1 = cmpb_r[1];
   assign cmp_b2 = cmpb_r[0];
   assign busy   = busy_r;
   assign done   = done_r;
   assign gt     = gt_r;
   assign eq     = eq_r;
   assign lt     = lt_r;
   assign err    = err_r;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_comparator_ctrl
// Directed bench for serial_comparator_ctrl with a behavioural 2-bit
// comparator. Expected values are hand-derived from the operands.
// -----------------------------------------------------------------------------
module tb_serial_comparator_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] op_a = 8'h00;
   logic [7:0] op_b = 8'h00;
   logic       cmp_a1, cmp_a2, cmp_b1, cmp_b2;
   logic       cmp_f1, cmp_f2, cmp_f3;
   logic       busy, done, gt, eq, lt, err;
   logic       force_bad = 1'b0;
   logic [2:0] f_model;

   int n_cmp = 0;
   int n_bad = 0;

   serial_comparator_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
      .cmp_a1(cmp_a1), .cmp_a2(cmp_a2), .cmp_b1(cmp_b1), .cmp_b2(cmp_b2),
      .cmp_f1(cmp_f1), .cmp_f2(cmp_f2), .cmp_f3(cmp_f3),
      .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt), .err(err)
   );

   always #5 clk = ~clk;

   // Behavioural 2-bit comparator, optionally forced to an illegal response.
   always_comb begin
      f_model = 3'b000;
      if (force_bad)                                   f_model = 3'b000;
      else if ({cmp_a1, cmp_a2} > {cmp_b1, cmp_b2})    f_model = 3'b100;
      else if ({cmp_a1, cmp_a2} < {cmp_b1, cmp_b2})    f_model = 3'b001;
      else                                             f_model = 3'b010;
   end
   assign {cmp_f1, cmp_f2, cmp_f3} = f_model;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] cmp_bus();
      return {cmp_a1, cmp_a2, cmp_b1, cmp_b2};
   endfunction

   // Slice sequence expected for 0x12 vs 0x13 ({a1,a2,b1,b2} per CMP cycle).
   logic [3:0] sl_1213 [4] = '{4'b0000, 4'b0101, 4'b0000, 4'b1011};

   // One comparison: start is high in cycle N; done expected in cycle N+k+1.
   // res = {gt, eq, lt, err}.
   task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int k, input logic [3:0] res, input bit chk_sl);
      int cyc;
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op_a  = ~a;          // later operand changes must not matter
      op_b  = a;
      cyc   = 1;
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
      while (!done && cyc < 20) begin
         if (chk_sl && cyc <= 4) check_val({tag, "_slice"}, 32'(cmp_bus()), 32'(sl_1213[cyc-1]));
         @(posedge clk); #1;
         cyc++;
      end
      check_val({tag, "_latency"}, 32'(cyc), 32'(k + 1));
      check_val({tag, "_result"}, 32'({gt, eq, lt, err}), 32'(res));
      check_val({tag, "_cmp_done"}, 32'(cmp_bus()), 32'd0);
      check_val({tag, "_busy_done"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
      check_val({tag, "_idle"}, 32'(busy), 32'd0);
      check_val({tag, "_hold"}, 32'({gt, eq, lt, err}), 32'(res));
   endtask

   initial begin
      int done_cnt;
      int first_done;
      int second_done;

      // Reset state.
      #2;
      check_val("rst_outputs", 32'({busy, done, gt, eq, lt, err}), 32'd0);
      check_val("rst_cmp", 32'(cmp_bus()), 32'd0);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      run_cmp("eq_a5",   8'hA5, 8'hA5, 4, 4'b0100, 1'b0);
      run_cmp("gt_c0",   8'hC0, 8'h80, 1, 4'b1000, 1'b0);
      run_cmp("lt_12",   8'h12, 8'h13, 4, 4'b0010, 1'b1);
      run_cmp("lt_msb",  8'h3F, 8'h40, 1, 4'b0010, 1'b0);
      run_cmp("gt_lsb",  8'h01, 8'h00, 4, 4'b1000, 1'b0);
      force_bad = 1'b1;
      run_cmp("err_000", 8'h55, 8'h55, 1, 4'b0001, 1'b0);
      force_bad = 1'b0;
      run_cmp("eq_zero", 8'h00, 8'h00, 4, 4'b0100, 1'b0);

      // Start held high for 10 cycles: accepted at cycle N and again at N+6.
      op_a = 8'h12; op_b = 8'h13;
      done_cnt = 0; first_done = 0; second_done = 0;
      start = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (c == 10) start = 1'b0;
         @(posedge clk); #1;
         if (done) begin
            done_cnt++;
            if (first_done == 0) first_done = c + 1;
            else if (second_done == 0) second_done = c + 1;
         end
      end
      check_val("hold_done_cycles", 32'(done_cnt), 32'd2);
      check_val("hold_first_done", 32'(first_done), 32'd5);
      check_val("hold_second_done", 32'(second_done), 32'd11);
      check_val("hold_result", 32'({gt, eq, lt, err}), 32'b0010);
      check_val("hold_idle", 32'(busy), 32'd0);

      // Reset during CMP (idx=2) aborts with no done pulse.
      op_a = 8'hA5; op_b = 8'hA5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check_val("abort_busy_pre", 32'(busy), 32'd1);
      check_val("abort_slice_pre", 32'(cmp_bus()), 32'b1010);
      #2 rst_n = 1'b0;
      #1;
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_cmp", 32'(cmp_bus()), 32'd0);
      check_val("abort_done", 32'(done), 32'd0);
      done_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
      end
      check_val("abort_no_done", 32'(done_cnt), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_cmp("post_rst", 8'hFF, 8'h00, 1, 4'b1000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_comparator_ctrl.md
SERIAL_COMPARATOR_CTRL -- requirements
Module: serial_comparator_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; SHALL be even and >= 2; SLICES = WIDTH/2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to compare op_a/op_b; sampled only in IDLE.
REQ-005 op_a  input  WIDTH  operand A, unsigned, captured on accepted start.
REQ-006 op_b  input  WIDTH  operand B, unsigned, captured on accepted start.
REQ-007 cmp_a1, cmp_a2  output  1 each  A slice to the 2-bit comparator; cmp_a1 is the MSB.
REQ-008 cmp_b1, cmp_b2  output  1 each  B slice to the 2-bit comparator; cmp_b1 is the MSB.
REQ-009 cmp_f1, cmp_f2, cmp_f3  input  1 each  comparator result: A>B, A==B, A<B; combinational from cmp_a*/cmp_b*.
REQ-010 busy  output  1  high whenever state != IDLE.
REQ-011 done  output  1  one-cycle pulse when the result is valid.
REQ-012 gt, eq, lt  output  1 each  registered final result (op_a >, ==, < op_b).
REQ-013 err  output  1  comparator returned a non-one-hot response.

Function
REQ-014 FSM states: IDLE, CMP, DONE; SHALL have no other reachable state.
REQ-015 IDLE: on start=1, register op_a/op_b, set idx=SLICES-1, clear gt/eq/lt/err, go to CMP; otherwise stay.
REQ-016 CMP: drive {cmp_a1,cmp_a2}=op_a_reg[2*idx+1:2*idx] and {cmp_b1,cmp_b2}=op_b_reg[2*idx+1:2*idx]; sample cmp_f* in the same cycle. Slices go MSB first.
REQ-017 CMP, f=100: set gt=1 and go to DONE (early termination).
REQ-018 CMP, f=001: set lt=1 and go to DONE (early termination).
REQ-019 CMP, f=010 and idx>0: decrement idx and stay in CMP.
REQ-020 CMP, f=010 and idx==0: set eq=1 and go to DONE.
REQ-021 CMP, any other f pattern (not one-hot): set err=1, keep gt/eq/lt=0, go to DONE.
REQ-022 DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
REQ-023 Latency: start accepted at edge N; k slices evaluated (1..SLICES); done high in cycle N+k+1; worst case SLICES+1 cycles.
REQ-024 cmp_a*/cmp_b* SHALL be 0 in IDLE and DONE.
REQ-025 start while busy (CMP or DONE) SHALL be ignored and have no effect on the result.
REQ-026 A new start in the IDLE cycle after DONE SHALL be accepted (back-to-back throughput = k+2 cycles).
REQ-027 gt/eq/lt/err SHALL hold their value from DONE until the next accepted start; at most one of gt/eq/lt/err is 1.
REQ-028 op_a/op_b changes after acceptance SHALL NOT affect the ongoing comparison.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, idx=0, busy=0, done=0, gt=eq=lt=err=0, cmp_*=0, operand registers=0.
REQ-030 Reset asserted mid-comparison SHALL abort it with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-031 op_a=0xA5, op_b=0xA5, start at N -> 4 slices compared (f=010 each); done at N+5; eq=1, gt=lt=err=0.
REQ-032 op_a=0xC0, op_b=0x80 -> first slice 11 vs 10 gives f=100; done at N+2; gt=1; cmp_* return to 0 in DONE.
REQ-033 op_a=0x12, op_b=0x13 -> slices 00/00, 01/01, 00/00, 10/11; done at N+5; lt=1.
REQ-034 start held high for 10 cycles with 0x12/0x13 -> exactly one comparison, then a second accepted in the IDLE cycle after DONE; done pulses are exactly 1 cycle each.
REQ-035 Comparator model forced to f=000 on the first slice -> done at N+2, err=1, gt=eq=lt=0.
REQ-036 rst_n pulsed low during CMP (idx=2) -> busy=0 and cmp_*=0 immediately, no done pulse; a following 0xFF/0x00 compare -> gt=1 at N+2.
